clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable clock divider / tick generator for board-level timing (e.g. 100 MHz to 1 Hz or display refresh rates).
- Generalises the fixed-divisor divider with:
  - parametrised counter width and reset divisor
  - glitch-free divisor reload at period boundaries
  - toggle (square) and pulse (one-cycle enable) modes
  - enable, phase restart, and status outputs
- All outputs are registered in the Clk domain. ClkOut is intended as a clock-enable or slow LED/visual clock, not a routed clock.

Parameters:
- WIDTH, 26, width of counter, divisor input and Count output.
- DEFAULT_DIV, 100, divisor value loaded at reset. Must fit in WIDTH bits.

Ports:
- Clk  input  1  system clock, all logic on posedge.
- Rst  input  1  asynchronous, active-high reset.
- En  input  1  count enable. When 0, the counter and ClkOut freeze.
- Load  input  1  one-cycle strobe: capture DivIn as the new divisor.
- DivIn  input  WIDTH  new divisor D. Period unit is D+1 Clk cycles.
- Mode  input  1  0 = toggle (square wave), 1 = pulse (one-cycle high).
- Restart  input  1  one-cycle strobe: restart phase from 0.
- ClkOut  output  1  divided output.
- Tick  output  1  one-cycle pulse on every terminal count, in both modes.
- Pending  output  1  a loaded divisor is waiting for the next boundary.
- Count  output  WIDTH  current counter value, for debug.

Behaviour:
- Internal state: Cnt, DivAct (active divisor), DivShd (shadow divisor), Pending.
- Reset, asynchronous, any time including mid-period:
  - Cnt = 0, DivAct = DivShd = DEFAULT_DIV, Pending = 0, ClkOut = 0, Tick = 0.
  - Normal operation resumes on the first posedge after Rst falls.
- Terminal event (TC): En = 1 and Cnt == DivAct in a given cycle. Outputs update at that cycle's closing edge, i.e. 1-cycle registered latency.
- Per-edge priority, highest first:
  1. Restart:
     - Cnt <= 0, ClkOut <= 0, Tick <= 0.
     - If Load is also high, DivAct <= DivIn and Pending <= 0.
     - Else if Pending, DivAct <= DivShd and Pending <= 0.
     - Acts regardless of En.
  2. Load with En = 0:
     - DivAct <= DivIn immediately, Cnt <= 0, Pending <= 0.
     - ClkOut holds.
  3. En = 0 with no strobes: Cnt, ClkOut, DivAct and Pending hold; Tick <= 0.
  4. En = 1, TC:
     - Cnt <= 0, Tick <= 1.
     - ClkOut <= ~ClkOut if Mode = 0; ClkOut <= 1 if Mode = 1.
     - If Pending, DivAct <= DivShd and Pending <= 0.
     - If Load is high in the same cycle:
       - DivShd <= DivIn and Pending <= 1.
       - The value is NOT applied at this TC; it applies at the following TC.
  5. En = 1, no TC:
     - Cnt <= Cnt + 1, Tick <= 0.
     - ClkOut holds if Mode = 0; ClkOut <= 0 if Mode = 1.
     - If Load, DivShd <= DivIn and Pending <= 1. A later Load overwrites an earlier pending one (last wins).
- Periods, with En held high:
  - Tick: every D+1 cycles.
  - Mode 0: ClkOut period 2*(D+1) cycles, 50 % duty.
  - Mode 1: ClkOut high 1 cycle every D+1 cycles.
- D = 0:
  - TC every cycle, so Tick is held high continuously.
  - Mode 0: ClkOut = Clk/2. Mode 1: ClkOut held high.
- D = 2^WIDTH-1 is legal. Cnt never exceeds DivAct, so no overflow wrap occurs.
- Mode is sampled every cycle and needs no synchronisation. When switching 0->1 with ClkOut high, ClkOut falls on the next non-TC cycle.
- Cnt > DivAct cannot arise: DivAct changes only when Cnt is 0 or forced to 0.
- Count = Cnt. Pending is the direct register value.

Test Plan:
- Reset, DEFAULT_DIV = 100, En = 1, Mode = 0 -> first ClkOut rise 101 cycles after reset release; period 202 cycles; Tick every 101 cycles; Rst asserted mid-period clears all outputs asynchronously (no clock edge needed).
- En = 1, Load DivIn = 4 mid-period while DivAct = 9 -> Pending = 1; current period completes at 10 cycles; subsequent Tick spacing 5 cycles; Pending clears on that TC.
- Load DivIn = 3 in the exact TC cycle, then Load DivIn = 6 before the next TC -> next period still uses old D; DivAct becomes 6 (last wins); Tick spacing 7 thereafter.
- Mode = 1, D = 0 -> Tick and ClkOut constantly 1. Then D = 2 via Load with En = 0 -> Cnt = 0 immediately; after re-enable, ClkOut high 1 cycle every 3 cycles.
- En toggled low for 20 cycles at Cnt = 5 -> Count holds 5, Tick = 0, ClkOut frozen; after En high, TC occurs exactly D-5 cycles later.
- Restart + Load DivIn = 7 same cycle while Pending = 1 from an earlier Load of 2 -> Cnt = 0, ClkOut = 0, DivAct = 7, Pending = 0; Tick after 8 cycles.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// Latency: none, plain wires between the driver and the divider.
// Backpressure: none; every strobe is consumed on the edge that samples it.
//
// Ports carried:
//   En, Load, DivIn, Mode, Restart  - controls driven toward the divider
//   ClkOut, Tick, Pending, Count    - registered status from the divider
interface clk_div_prog_if #(
  parameter int WIDTH = 26
);
  logic             En;
  logic             Load;
  logic [WIDTH-1:0] DivIn;
  logic             Mode;
  logic             Restart;
  logic             ClkOut;
  logic             Tick;
  logic             Pending;
  logic [WIDTH-1:0] Count;

  // Controller side: drives the strobes/divisor, observes status.
  modport master (
    output En, Load, DivIn, Mode, Restart,
    input  ClkOut, Tick, Pending, Count
  );

  // Divider side.
  modport slave (
    input  En, Load, DivIn, Mode, Restart,
    output ClkOut, Tick, Pending, Count
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider / tick generator with glitch-free divisor reload.
// Latency: one Clk cycle from a terminal-count cycle to ClkOut/Tick update.
// Backpressure: none; En freezes the counter, Load/Restart strobes act on the sampling edge.
//
// Ports:
//   Clk  - system clock, all state updates on posedge
//   Rst  - asynchronous active-high reset
//   Bus  - clk_div_prog_if.slave:
//            En      count enable (0 freezes counter and ClkOut)
//            Load    one-cycle strobe to capture DivIn as the new divisor
//            DivIn   divisor D, period unit is D+1 Clk cycles
//            Mode    0 = square wave on ClkOut, 1 = one-cycle pulse on ClkOut
//            Restart one-cycle strobe restarting the phase from zero
//            ClkOut  divided output (clock-enable / visual clock, not a routed clock)
//            Tick    one-cycle pulse per terminal count
//            Pending a loaded divisor waits for the next period boundary
//            Count   current counter value
module clk_div_prog #(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 100
) (
  input  logic          Clk,
  input  logic          Rst,
  clk_div_prog_if.slave Bus
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

  // Registered state
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] divAct;   // divisor governing the current period
  logic [WIDTH-1:0] divShd;   // divisor waiting to take over at the next boundary
  logic             pending;
  logic             clkOut;
  logic             tick;

  // Next-state values
  logic [WIDTH-1:0] cntNxt;
  logic [WIDTH-1:0] divActNxt;
  logic [WIDTH-1:0] divShdNxt;
  logic             pendingNxt;
  logic             clkOutNxt;
  logic             tickNxt;

  // Terminal count. Cnt is only ever reset to 0 or incremented up to divAct,
  // and divAct only changes when Cnt is 0 or being forced to 0, so an
  // equality compare is sufficient; no wrap can occur even at the all-ones divisor.
  logic tc;
  assign tc = Bus.En && (cnt == divAct);

  always_comb begin
    cntNxt     = cnt;
    divActNxt  = divAct;
    divShdNxt  = divShd;
    pendingNxt = pending;
    clkOutNxt  = clkOut;
    tickNxt    = 1'b0;

    if (Bus.Restart) begin
      // Phase restart wins over everything and ignores En. A simultaneous
      // Load is applied directly; otherwise any waiting divisor is promoted
      // because the period boundary is being forced right now.
      cntNxt    = '0;
      clkOutNxt = 1'b0;
      if (Bus.Load) begin
        divActNxt  = Bus.DivIn;
        pendingNxt = 1'b0;
      end else if (pending) begin
        divActNxt  = divShd;
        pendingNxt = 1'b0;
      end
    end else if (Bus.Load && !Bus.En) begin
      // While frozen there is no running period to protect, so the new
      // divisor takes effect at once and the phase starts over. ClkOut holds.
      divActNxt  = Bus.DivIn;
      cntNxt     = '0;
      pendingNxt = 1'b0;
    end else if (!Bus.En) begin
      // Frozen: everything holds, only the Tick pulse drops.
    end else if (tc) begin
      cntNxt    = '0;
      tickNxt   = 1'b1;
      clkOutNxt = Bus.Mode ? 1'b1 : ~clkOut;
      if (pending) begin
        divActNxt  = divShd;
        pendingNxt = 1'b0;
      end
      // A Load landing on the boundary cycle is queued for the following
      // boundary; the divisor promoted above (if any) governs the next period.
      if (Bus.Load) begin
        divShdNxt  = Bus.DivIn;
        pendingNxt = 1'b1;
      end
    end else begin
      cntNxt = cnt + WIDTH'(1);
      // Pulse mode drops ClkOut after its single high cycle; this also
      // covers a 0->1 Mode switch while ClkOut was high.
      if (Bus.Mode) begin
        clkOutNxt = 1'b0;
      end
      // Later Loads within the same period overwrite earlier ones.
      if (Bus.Load) begin
        divShdNxt  = Bus.DivIn;
        pendingNxt = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt     <= '0;
      divAct  <= RST_DIV;
      divShd  <= RST_DIV;
      pending <= 1'b0;
      clkOut  <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cntNxt;
      divAct  <= divActNxt;
      divShd  <= divShdNxt;
      pending <= pendingNxt;
      clkOut  <= clkOutNxt;
      tick    <= tickNxt;
    end
  end

  assign Bus.ClkOut  = clkOut;
  assign Bus.Tick    = tick;
  assign Bus.Pending = pending;
  assign Bus.Count   = cnt;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: expected values queued per step, popped at observation.
module tb_clk_div_prog;

  localparam int W = 26;

  logic Clk;
  logic Rst;

  clk_div_prog_if #(.WIDTH(W)) bus ();

  clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(100)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .Bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nErrors = 0;

  task automatic sbPush(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbQ.push_back(e);
  endtask

  task automatic sbCheck(input logic [31:0] obs);
    exp_t e;
    nChecks++;
    if (sbQ.size() == 0) begin
      nErrors++;
      $error("FAIL scoreboard_empty: observed %0d, no expected entry", obs);
    end else begin
      e = sbQ.pop_front();
      assert (obs === e.val) else begin
        nErrors++;
        $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Each wait returns the number of edges taken, or -1 if the budget expired.
  task automatic waitTick(input int budget, output int n);
    int  i = 0;
    bit  found = 0;
    while (!found && i < budget) begin
      step();
      i++;
      if (bus.Tick === 1'b1) found = 1;
    end
    n = found ? i : -1;
  endtask

  task automatic waitClkOut(input logic level, input int budget, output int n);
    int  i = 0;
    bit  found = 0;
    while (!found && i < budget) begin
      step();
      i++;
      if (bus.ClkOut === level) found = 1;
    end
    n = found ? i : -1;
  endtask

  task automatic waitCount(input int value, input int budget, output int n);
    int  i = 0;
    bit  found = 0;
    while (!found && i < budget) begin
      step();
      i++;
      if (bus.Count === W'(value)) found = 1;
    end
    n = found ? i : -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    int ticks;

    Rst         = 1'b1;
    bus.En      = 1'b1;
    bus.Load    = 1'b0;
    bus.DivIn   = '0;
    bus.Mode    = 1'b0;
    bus.Restart = 1'b0;

    // ---- Reset state ----
    #12;
    sbPush("rst_count", 0);    sbCheck(32'(bus.Count));
    sbPush("rst_clkout", 0);   sbCheck(32'(bus.ClkOut));
    sbPush("rst_tick", 0);     sbCheck(32'(bus.Tick));
    sbPush("rst_pending", 0);  sbCheck(32'(bus.Pending));
    step();
    Rst = 1'b0;

    // ---- Default divisor 100, toggle mode ----
    sbPush("first_rise_edges", 101);
    waitClkOut(1'b1, 300, n);
    sbCheck(32'(n));
    sbPush("first_rise_tick", 1);
    sbCheck(32'(bus.Tick));
    step();
    sbPush("tick_one_cycle", 0);
    sbCheck(32'(bus.Tick));
    sbPush("tick_spacing_101", 101);
    waitTick(300, n);
    sbCheck(32'(n + 1));
    sbPush("clkout_period_202", 202);
    waitClkOut(1'b1, 300, n2);
    sbCheck(32'(101 + n2));

    // ---- Asynchronous reset mid-period ----
    repeat (50) step();
    #3;
    Rst = 1'b1;
    #2;
    sbPush("async_rst_count", 0);   sbCheck(32'(bus.Count));
    sbPush("async_rst_clkout", 0);  sbCheck(32'(bus.ClkOut));
    step();
    Rst = 1'b0;

    // ---- D=9 then Load 4 mid-period ----
    bus.En = 1'b0; bus.Load = 1'b1; bus.DivIn = W'(9);
    step();
    bus.Load = 1'b0; bus.En = 1'b1;
    repeat (3) step();
    bus.Load = 1'b1; bus.DivIn = W'(4);
    step();
    bus.Load = 1'b0;
    sbPush("midload_pending", 1);
    sbCheck(32'(bus.Pending));
    sbPush("midload_period_10", 10);
    waitTick(50, n);
    sbCheck(32'(4 + n));
    sbPush("midload_pending_clr", 0);
    sbCheck(32'(bus.Pending));
    sbPush("d4_spacing_a", 5);
    waitTick(50, n);
    sbCheck(32'(n));
    sbPush("d4_spacing_b", 5);
    waitTick(50, n);
    sbCheck(32'(n));

    // ---- Load on the TC cycle, then overwrite (last wins) ----
    sbPush("reach_cnt4", 4);
    waitCount(4, 50, n);
    sbCheck(32'(n));
    bus.Load = 1'b1; bus.DivIn = W'(3);
    step();
    bus.Load = 1'b0;
    sbPush("tcload_tick", 1);
    sbCheck(32'(bus.Tick));
    sbPush("tcload_pending", 1);
    sbCheck(32'(bus.Pending));
    repeat (2) step();
    bus.Load = 1'b1; bus.DivIn = W'(6);
    step();
    bus.Load = 1'b0;
    sbPush("old_d_period_5", 5);
    waitTick(50, n);
    sbCheck(32'(3 + n));
    sbPush("lastwins_pending_clr", 0);
    sbCheck(32'(bus.Pending));
    sbPush("d6_spacing_a", 7);
    waitTick(50, n);
    sbCheck(32'(n));
    sbPush("d6_spacing_b", 7);
    waitTick(50, n);
    sbCheck(32'(n));

    // ---- Pulse mode, D=0 ----
    bus.Mode = 1'b1;
    bus.En = 1'b0; bus.Load = 1'b1; bus.DivIn = '0;
    step();
    bus.Load = 1'b0; bus.En = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      sbPush("d0_tick_clkout", 3);
      sbCheck(32'({bus.Tick, bus.ClkOut}));
    end

    // ---- Load D=2 while disabled, then pulse every 3 cycles ----
    bus.En = 1'b0; bus.Load = 1'b1; bus.DivIn = W'(2);
    step();
    bus.Load = 1'b0;
    sbPush("dis_load_count", 0);   sbCheck(32'(bus.Count));
    sbPush("dis_load_tick", 0);    sbCheck(32'(bus.Tick));
    sbPush("dis_load_clkout", 1);  sbCheck(32'(bus.ClkOut));
    bus.En = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      sbPush("d2_pulse", (i % 3 == 0) ? 3 : 0);
      sbCheck(32'({bus.Tick, bus.ClkOut}));
    end

    // ---- Freeze at Cnt=5 for 20 cycles, D=12, toggle mode ----
    bus.Mode = 1'b0;
    bus.En = 1'b0; bus.Load = 1'b1; bus.DivIn = W'(12);
    step();
    bus.Load = 1'b0; bus.En = 1'b1;
    sbPush("reach_cnt5", 5);
    waitCount(5, 50, n);
    sbCheck(32'(n));
    bus.En = 1'b0;
    ticks = 0;
    repeat (20) begin
      step();
      if (bus.Tick !== 1'b0) ticks++;
    end
    sbPush("freeze_count", 5);    sbCheck(32'(bus.Count));
    sbPush("freeze_ticks", 0);    sbCheck(32'(ticks));
    sbPush("freeze_clkout", 1);   sbCheck(32'(bus.ClkOut));
    bus.En = 1'b1;
    sbPush("resume_tc_edges", 8);
    waitTick(50, n);
    sbCheck(32'(n));
    sbPush("resume_clkout", 0);
    sbCheck(32'(bus.ClkOut));

    // ---- Restart + Load while an older Load is pending ----
    sbPush("d12_spacing", 13);
    waitTick(50, n);
    sbCheck(32'(n));
    repeat (3) step();
    bus.Load = 1'b1; bus.DivIn = W'(2);
    step();
    bus.Load = 1'b0;
    sbPush("pre_restart_pending", 1);
    sbCheck(32'(bus.Pending));
    repeat (2) step();
    bus.Restart = 1'b1; bus.Load = 1'b1; bus.DivIn = W'(7);
    step();
    bus.Restart = 1'b0; bus.Load = 1'b0;
    sbPush("restart_count", 0);    sbCheck(32'(bus.Count));
    sbPush("restart_clkout", 0);   sbCheck(32'(bus.ClkOut));
    sbPush("restart_pending", 0);  sbCheck(32'(bus.Pending));
    sbPush("restart_tick", 0);     sbCheck(32'(bus.Tick));
    sbPush("restart_first_tick", 8);
    waitTick(50, n);
    sbCheck(32'(n));
    sbPush("restart_d7_spacing", 8);
    waitTick(50, n);
    sbCheck(32'(n));

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
